// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - AXI4-Lite master driven by a valid/ready command stream
//
// Purpose: accepts one command at a time (read or write, address, data, strobes),
// runs a single AXI4-Lite transaction and returns one response carrying RDATA/RRESP
// or BRESP. AW and W are issued together; each drops independently after its own
// handshake.
//
// Ports:
//   aclk, areset_n                 clock, asynchronous active-low reset
//   cmd_*                          command stream (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                          response stream (valid/ready, write, rdata, resp)
//   m_aw*, m_w*, m_b*, m_ar*, m_r* AXI4-Lite master channels
//   timeout_err                    sticky watchdog flag
//
// Optional feature: define AXI_LITE_MASTER_TIMEOUT_EN to enable the watchdog that
// sets timeout_err after TIMEOUT_CYCLES cycles in any waiting state.

module axi_lite_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic                    timeout_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_RDATA,
        S_WRITE,
        S_WRESP,
        S_RSP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic                    write_q;
    logic                    aw_done;
    logic                    w_done;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;

    // Every output below is decoded from registered state only.
    assign cmd_ready = (state == S_IDLE);
    assign m_arvalid = (state == S_RADDR);
    assign m_rready  = (state == S_RDATA);
    assign m_awvalid = (state == S_WRITE) && !aw_done;
    assign m_wvalid  = (state == S_WRITE) && !w_done;
    assign m_bready  = (state == S_WRESP);
    assign rsp_valid = (state == S_RSP);

    assign m_awprot  = 3'b000;
    assign m_arprot  = 3'b000;
    assign m_araddr  = m_arvalid ? addr_q  : '0;
    assign m_awaddr  = m_awvalid ? addr_q  : '0;
    assign m_wdata   = m_wvalid  ? wdata_q : '0;
    assign m_wstrb   = m_wvalid  ? wstrb_q : '0;

    assign rsp_write = write_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_next = cmd_write ? S_WRITE : S_RADDR;
            S_RADDR: if (m_arready) state_next = S_RDATA;
            S_RDATA: if (m_rvalid)  state_next = S_RSP;
            // A channel is finished if it completed earlier or handshakes now.
            S_WRITE: if ((aw_done || m_awready) && (w_done || m_wready)) state_next = S_WRESP;
            S_WRESP: if (m_bvalid)  state_next = S_RSP;
            S_RSP:   if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            write_q <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        write_q <= cmd_write;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (m_awready) aw_done <= 1'b1;
                    if (m_wready)  w_done  <= 1'b1;
                end
                S_RDATA: begin
                    if (m_rvalid) begin
                        rdata_q <= m_rdata;
                        resp_q  <= m_rresp;
                    end
                end
                S_WRESP: begin
                    if (m_bvalid) begin
                        rdata_q <= '0;
                        resp_q  <= m_bresp;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             wd_err;
    logic             waiting;

    assign waiting     = (state == S_RADDR) || (state == S_RDATA) ||
                         (state == S_WRITE) || (state == S_WRESP);
    assign timeout_err = wd_err;

    // The counter restarts on every state change; the flag is raised on the edge
    // where the count reaches the limit, even if the state happens to leave then.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else begin
            if (state_next != state) begin
                wd_cnt <= '0;
            end else if (waiting && (wd_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (waiting && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                wd_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - self-checking bench for axi_lite_cmd_master

module tb_axi_lite_cmd_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          aclk;
    logic          areset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] m_awaddr;
    logic [2:0]    m_awprot;
    logic          m_awvalid;
    logic          m_awready;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic          m_wvalid;
    logic          m_wready;
    logic [1:0]    m_bresp;
    logic          m_bvalid;
    logic          m_bready;
    logic [AW-1:0] m_araddr;
    logic [2:0]    m_arprot;
    logic          m_arvalid;
    logic          m_arready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rvalid;
    logic          m_rready;
    logic          timeout_err;

    axi_lite_cmd_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .aclk        (aclk),
        .areset_n    (areset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .m_awaddr    (m_awaddr),
        .m_awprot    (m_awprot),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_bresp     (m_bresp),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .m_araddr    (m_araddr),
        .m_arprot    (m_arprot),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready),
        .timeout_err (timeout_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    bit to_sticky = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bresp   = 2'b00;
        m_bvalid  = 1'b0;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_rvalid  = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_awvalid"}, m_awvalid, 0);
        chk({tag, "_wvalid"},  m_wvalid,  0);
        chk({tag, "_arvalid"}, m_arvalid, 0);
        chk({tag, "_bready"},  m_bready,  0);
        chk({tag, "_rready"},  m_rready,  0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
    endtask

    // One command run against a slave whose behaviour is a timeline: each ready or
    // response valid is a single-cycle pulse at a cycle derived from the latencies.
    // Expected master outputs for every cycle follow from the same timeline.
    task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] strb, input int lat_a, input int lat_w,
                           input int lat_resp, input int lat_rsp,
                           input logic [DW-1:0] sdata, input logic [1:0] sresp);
        int t_a, t_w, t_p2, t_h, t_end;
        bit e_aw, e_w, e_ar, e_b, e_r, e_rsp;
        @(negedge aclk);
        clear_inputs();
        chk("cmd_ready_idle", cmd_ready, 1);
        chk_quiet("idle");
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
        @(posedge aclk);
        t_a   = 1 + lat_a;
        t_w   = wr ? 1 + lat_w : 0;
        t_p2  = ((wr && t_w > t_a) ? t_w : t_a) + 1;
        t_h   = t_p2 + lat_resp;
        t_end = t_h + 1 + lat_rsp;
        for (int c = 1; c <= t_end; c++) begin
            @(negedge aclk);
            if (TMO_EN && (((t_p2 - 1) >= TMO && c >= 1 + TMO) ||
                           ((lat_resp + 1) >= TMO && c >= t_p2 + TMO)))
                to_sticky = 1'b1;
            e_aw  = wr && (c <= t_a);
            e_w   = wr && (c <= t_w);
            e_ar  = !wr && (c <= t_a);
            e_b   = wr && (c >= t_p2) && (c <= t_h);
            e_r   = !wr && (c >= t_p2) && (c <= t_h);
            e_rsp = (c > t_h);
            chk("cmd_ready_busy", cmd_ready, 0);
            chk("awvalid", m_awvalid, e_aw);
            chk("awaddr",  m_awaddr,  e_aw ? addr : 0);
            chk("wvalid",  m_wvalid,  e_w);
            chk("wdata",   m_wdata,   e_w ? wdata : 0);
            chk("wstrb",   m_wstrb,   e_w ? strb : 0);
            chk("arvalid", m_arvalid, e_ar);
            chk("araddr",  m_araddr,  e_ar ? addr : 0);
            chk("awprot",  m_awprot,  0);
            chk("arprot",  m_arprot,  0);
            chk("bready",  m_bready,  e_b);
            chk("rready",  m_rready,  e_r);
            chk("rsp_valid", rsp_valid, e_rsp);
            if (e_rsp) begin
                chk("rsp_write", rsp_write, wr);
                chk("rsp_rdata", rsp_rdata, wr ? 0 : sdata);
                chk("rsp_resp",  rsp_resp,  sresp);
            end
            chk("timeout_err", timeout_err, to_sticky);
            // Unrelated command traffic while busy must be ignored.
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            cmd_wstrb = 4'($urandom);
            m_awready = wr && (c == t_a);
            m_wready  = wr && (c == t_w);
            m_arready = !wr && (c == t_a);
            m_bvalid  = wr && (c == t_h);
            m_bresp   = (c == t_h) ? sresp : 2'($urandom);
            m_rvalid  = !wr && (c == t_h);
            m_rdata   = (c == t_h) ? sdata : $urandom;
            m_rresp   = (c == t_h) ? sresp : 2'($urandom);
            rsp_ready = (c == t_end);
            @(posedge aclk);
        end
    endtask

    initial begin
        clear_inputs();
        areset_n = 1'b0;
        repeat (2) @(negedge aclk);
        chk_quiet("reset");
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_resp",  rsp_resp,  0);
        chk("reset_awaddr",    m_awaddr,  0);
        chk("reset_araddr",    m_araddr,  0);
        chk("reset_timeout",   timeout_err, 0);
        areset_n = 1'b1;
        @(negedge aclk);
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // Zero-wait read returning DEADBEEF / OKAY.
        run_cmd(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00);
        // Write with AW accepted three cycles late, W immediately.
        run_cmd(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011, 3, 0, 0, 0, 32'h0, 2'b00);
        // Read with SLVERR passed through.
        run_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1, 0, 2, 0, 32'hA5A5_0F0F, 2'b10);
        // Back-to-back write then read, each response held off five cycles.
        run_cmd(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'b1111, 0, 2, 1, 5, 32'h0, 2'b11);
        run_cmd(1'b0, 32'h0000_0034, 32'h0, 4'h0, 0, 0, 0, 5, 32'h0BAD_CAFE, 2'b00);

        // Reset in the middle of a write while AW is still pending.
        @(negedge aclk);
        clear_inputs();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0040;
        cmd_wdata = 32'h1111_2222;
        cmd_wstrb = 4'hF;
        @(negedge aclk);
        cmd_valid = 1'b0;
        m_wready  = 1'b1;
        @(negedge aclk);
        m_wready  = 1'b0;
        chk("midwrite_awvalid", m_awvalid, 1);
        areset_n = 1'b0;
        #1;
        chk_quiet("midreset");
        chk("midreset_awaddr", m_awaddr, 0);
        to_sticky = 1'b0;
        @(negedge aclk);
        areset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("post_reset_cmd_ready", cmd_ready, 1);
            chk("post_reset_rsp_valid", rsp_valid, 0);
        end

        // Slow B response: long enough to trip the watchdog when it is built in.
        run_cmd(1'b1, 32'h0000_0050, 32'h5555_AAAA, 4'b1000, 0, 0, 20, 0, 32'h0, 2'b01);

        for (int n = 0; n < 40; n++) begin
            run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                    $urandom, 2'($urandom));
        end

        @(negedge aclk);
        clear_inputs();
        chk("final_cmd_ready", cmd_ready, 1);
        chk("final_rsp_valid", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
